request_fetch_unit: RTL and testbench
=====================================

Name: request_fetch_unit

Overview:
- Sequential fetch and request stage sitting on both sides of the single-cycle control unit.
- Owns the PC and the instruction register: fetches the word that feeds the control unit's instruction input.
- Consumes the control unit's PCSrc, immediate, immediate26, dREN, dWEN and halt outputs. Issues instruction and data memory requests, and pulses pc_en once per retired instruction.
- Also keeps retired-instruction and stall counters for performance readout.

Parameters:
- PC_INIT, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 32, width of the perf counters.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  synchronous reset, active-high.
- ihit  in  1  instruction memory has returned iload this cycle.
- iload  in  32  instruction word from instruction memory.
- dhit  in  1  data memory read or write has completed this cycle.
- dREN  in  1  from control: current instruction reads data memory.
- dWEN  in  1  from control: current instruction writes data memory.
- halt  in  1  from control: current instruction is HALT.
- PCSrc  in  3  from control: next-PC select, pcsrc_t encoding.
- immediate  in  16  from control: branch offset.
- immediate26  in  26  from control: jump target field.
- rs_data  in  32  register file rs value, used for JR.
- imemREN  out  1  instruction memory read request.
- imemaddr  out  32  instruction address; always equals pc.
- dmemREN  out  1  data memory read request.
- dmemWEN  out  1  data memory write request.
- instruction  out  32  latched instruction driven to the control unit.
- pc  out  32  current PC.
- pc_en  out  1  one-cycle pulse on the cycle pc updates.
- halted  out  1  sticky halt indicator.
- retired_cnt  out  CNT_W  count of retired instructions.
- stall_cnt  out  CNT_W  count of cycles spent waiting on ihit or dhit.

Behaviour:
Reset values (RST high at a rising edge):
- state=FETCH, pc=PC_INIT, instruction=0, halted=0, both counters=0, pc_en=0.
- Reset mid-operation aborts any outstanding request; the request outputs drop the cycle after.

FSM states FETCH, EXEC, MEM, HALT:
- FETCH
  - imemREN=1.
  - On ihit: instruction<=iload, go to EXEC.
  - Otherwise stall_cnt++.
- EXEC (one cycle; control decodes instruction combinationally)
  - halt=1: go to HALT. No memory request, pc is not updated, halt takes priority over dREN/dWEN.
  - Else if dREN or dWEN: go to MEM.
  - Else: pc<=next_pc, pc_en=1, retired_cnt++, go to FETCH.
- MEM
  - dmemREN=dREN, dmemWEN=dWEN, imemREN=0; instruction memory is never requested in this state.
  - If dREN and dWEN are both 1: only dmemWEN is asserted.
  - On dhit: pc<=next_pc, pc_en=1, retired_cnt++, go to FETCH.
  - Otherwise stall_cnt++.
- HALT
  - Absorbing until RST. halted=1, all request outputs 0, counters frozen.

Other rules:
- ihit outside FETCH and dhit outside MEM are ignored.
- Outside the states listed above, all request outputs are 0.
- pc_en is high for exactly one cycle per retired instruction.

next_pc (combinational, pc4 = pc + 4):
- PC_SEQ (0): pc4.
- PC_BR (1): pc4 + (sign-extended immediate << 2). Control has already resolved the condition from alu_zf.
- PC_J (2): {pc4[31:28], immediate26, 2'b00}.
- PC_JR (3): rs_data.
- Values 4-7: treated as PC_SEQ.

Width and boundary rules:
- All PC arithmetic is modulo 2^32; pc=32'hFFFF_FFFC with PC_SEQ wraps to 0.
- Counters wrap to 0 at their maximum value.

Decomposition:
- Add to cpu_types_pkg:
  - pcsrc_t, a 3-bit enum: PC_SEQ, PC_BR, PC_J, PC_JR.
  - fetch_state_t, an enum: FETCH, EXEC, MEM, HALT.
  - Constant PC_STEP = 4.
- Sub-module next_pc_gen: combinational next_pc from pc, PCSrc, immediate, immediate26 and rs_data.
- The FSM, PC register, instruction register and counters stay in the top module.

Test Plan:
- Reset then ihit after 2 wait cycles, iload=32'h2001_0005 (ADDI), PCSrc=0:
  - instruction=32'h2001_0005 one cycle after ihit.
  - pc_en pulses in EXEC; pc becomes 4.
  - retired_cnt=1, stall_cnt=2.
- LW: dREN=1, dhit after 3 cycles:
  - dmemREN is high for 4 cycles and imemREN is low throughout.
  - pc advances only on the dhit cycle.
  - stall_cnt increases by 3.
- Branch at pc=8, PCSrc=PC_BR, immediate=16'hFFFE -> pc=32'h0000_0004.
- Jump at pc=32'h1000_0000, PCSrc=PC_J, immediate26=26'h000_0040 -> pc=32'h1000_0100.
- JR with rs_data=32'h0000_0ABC -> pc=32'h0000_0ABC.
- HALT decoded with dWEN=1 -> dmemWEN stays 0, halted=1.
  - Further ihit/dhit have no effect and the counters stay frozen.
  - RST mid-MEM -> state=FETCH, pc=PC_INIT next cycle.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared types for the fetch/request stage: next-PC select encoding, FSM states
// and the sequential PC increment.
package cpu_types_pkg;

  typedef enum logic [2:0] {
    PC_SEQ = 3'd0,
    PC_BR  = 3'd1,
    PC_J   = 3'd2,
    PC_JR  = 3'd3
  } pcsrc_t;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    MEM   = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

  localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/next_pc_gen.sv
// Combinational next-PC selection: sequential, branch, jump or jump-register.
// Unused select codes fall back to the sequential address.
module next_pc_gen
  import cpu_types_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [2:0]  pcsrc_i,
  input  logic [15:0] imm_i,
  input  logic [25:0] imm26_i,
  input  logic [31:0] rs_data_i,
  output logic [31:0] next_pc_o
);

  logic [31:0] pc4;
  logic [31:0] br_off;

  always_comb begin
    pc4    = pc_i + PC_STEP;
    br_off = {{14{imm_i[15]}}, imm_i, 2'b00};
    case (pcsrc_i)
      PC_BR:   next_pc_o = pc4 + br_off;
      PC_J:    next_pc_o = {pc4[31:28], imm26_i, 2'b00};
      PC_JR:   next_pc_o = rs_data_i;
      default: next_pc_o = pc4;
    endcase
  end

endmodule

// File: rtl/request_fetch_unit.sv
// Fetch/request stage around the single-cycle control unit: owns PC and
// instruction register, sequences imem/dmem requests and keeps perf counters.
module request_fetch_unit
  import cpu_types_pkg::*;
#(
  parameter logic [31:0] PC_INIT = 32'h0000_0000,
  parameter int          CNT_W   = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic [31:0]      iload,
  input  logic             dhit,
  input  logic             dREN,
  input  logic             dWEN,
  input  logic             halt,
  input  logic [2:0]       PCSrc,
  input  logic [15:0]      immediate,
  input  logic [25:0]      immediate26,
  input  logic [31:0]      rs_data,
  output logic             imemREN,
  output logic [31:0]      imemaddr,
  output logic             dmemREN,
  output logic             dmemWEN,
  output logic [31:0]      instruction,
  output logic [31:0]      pc,
  output logic             pc_en,
  output logic             halted,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  fetch_state_t     state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [31:0]      next_pc;

  next_pc_gen u_next_pc_gen (
    .pc_i      (pc_q),
    .pcsrc_i   (PCSrc),
    .imm_i     (immediate),
    .imm26_i   (immediate26),
    .rs_data_i (rs_data),
    .next_pc_o (next_pc)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= FETCH;
      pc_q      <= PC_INIT;
      instr_q   <= 32'h0;
      retired_q <= '0;
      stall_q   <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
      stall_q   <= stall_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    stall_d   = stall_q;
    imemREN   = 1'b0;
    dmemREN   = 1'b0;
    dmemWEN   = 1'b0;
    pc_en     = 1'b0;
    halted    = 1'b0;
    case (state_q)
      FETCH: begin
        imemREN = 1'b1;
        if (ihit) begin
          instr_d = iload;
          state_d = EXEC;
        end else begin
          stall_d = stall_q + CNT_ONE;
        end
      end
      EXEC: begin
        // HALT wins over any memory access decoded alongside it
        if (halt) begin
          state_d = HALT;
        end else if (dREN || dWEN) begin
          state_d = MEM;
        end else begin
          pc_d      = next_pc;
          pc_en     = 1'b1;
          retired_d = retired_q + CNT_ONE;
          state_d   = FETCH;
        end
      end
      MEM: begin
        dmemWEN = dWEN;
        dmemREN = dREN && !dWEN;
        if (dhit) begin
          pc_d      = next_pc;
          pc_en     = 1'b1;
          retired_d = retired_q + CNT_ONE;
          state_d   = FETCH;
        end else begin
          stall_d = stall_q + CNT_ONE;
        end
      end
      HALT: begin
        halted = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

  assign imemaddr    = pc_q;
  assign pc          = pc_q;
  assign instruction = instr_q;
  assign retired_cnt = retired_q;
  assign stall_cnt   = stall_q;

endmodule

// File: tb/tb_request_fetch_unit.sv
// Directed bench for request_fetch_unit: a table of instructions with
// hand-computed PC/counter results, plus halt and reset-mid-MEM sequences.
module tb_request_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ihit, dhit, dren, dwen, halt_in;
  logic [31:0] iload, rs_data;
  logic [2:0]  pcsrc;
  logic [15:0] imm;
  logic [25:0] imm26;
  logic        imemren, dmemren, dmemwen, pc_en, halted;
  logic [31:0] imemaddr, instruction, pc;
  logic [31:0] retired_cnt, stall_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  request_fetch_unit dut (
    .CLK         (clk),
    .RST         (rst),
    .ihit        (ihit),
    .iload       (iload),
    .dhit        (dhit),
    .dREN        (dren),
    .dWEN        (dwen),
    .halt        (halt_in),
    .PCSrc       (pcsrc),
    .immediate   (imm),
    .immediate26 (imm26),
    .rs_data     (rs_data),
    .imemREN     (imemren),
    .imemaddr    (imemaddr),
    .dmemREN     (dmemren),
    .dmemWEN     (dmemwen),
    .instruction (instruction),
    .pc          (pc),
    .pc_en       (pc_en),
    .halted      (halted),
    .retired_cnt (retired_cnt),
    .stall_cnt   (stall_cnt)
  );

  typedef struct {
    int          iwait;
    logic [31:0] iload;
    logic [2:0]  pcsrc;
    logic [15:0] imm;
    logic [25:0] imm26;
    logic [31:0] rs;
    logic        dren;
    logic        dwen;
    int          dwait;
    logic [31:0] exp_pc;
    logic [31:0] exp_ret;
    logic [31:0] exp_stall;
    int          exp_ren;
    int          exp_wen;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Drives one instruction from FETCH back to FETCH, acting as the control unit.
  task automatic run_instr(input int idx, input vec_t v);
    int          ren_c, wen_c, imem_c, bad_c;
    logic [31:0] pc_before;
    ren_c = 0; wen_c = 0; imem_c = 0; bad_c = 0;
    pcsrc = v.pcsrc; imm = v.imm; imm26 = v.imm26; rs_data = v.rs;
    dren = v.dren; dwen = v.dwen; halt_in = 1'b0; dhit = 1'b0;
    ihit = 1'b0;
    for (int k = 0; k < v.iwait; k++) tick();
    ihit = 1'b1; iload = v.iload;
    tick();
    ihit = 1'b0; iload = 32'hDEAD_BEEF;
    pc_before = pc;
    chk($sformatf("v%0d_instr", idx), instruction, v.iload);
    chk($sformatf("v%0d_exec_pc_en", idx), {31'b0, pc_en}, {31'b0, !(v.dren || v.dwen)});
    if (v.dren || v.dwen) begin
      tick();
      for (int k = 0; k <= v.dwait; k++) begin
        dhit = (k == v.dwait);
        #1;
        if (dmemren) ren_c++;
        if (dmemwen) wen_c++;
        if (imemren) imem_c++;
        if (pc !== pc_before || pc_en !== dhit) bad_c++;
        tick();
      end
      dhit = 1'b0;
    end else begin
      tick();
    end
    chk($sformatf("v%0d_pc", idx), pc, v.exp_pc);
    chk($sformatf("v%0d_imemaddr", idx), imemaddr, v.exp_pc);
    chk($sformatf("v%0d_retired", idx), retired_cnt, v.exp_ret);
    chk($sformatf("v%0d_stall", idx), stall_cnt, v.exp_stall);
    chk($sformatf("v%0d_ren_cycles", idx), ren_c, v.exp_ren);
    chk($sformatf("v%0d_wen_cycles", idx), wen_c, v.exp_wen);
    chk($sformatf("v%0d_imem_in_mem", idx), imem_c, 0);
    chk($sformatf("v%0d_mem_pc_hold", idx), bad_c, 0);
    $display("[TB] vec %0d: pc=%h retired=%0d stall=%0d", idx, pc, retired_cnt, stall_cnt);
  endtask

  initial begin
    //        iwait iload         src   imm       imm26       rs            dR    dW   dwait exp_pc        ret stall ren wen
    vecs[0]  = '{2, 32'h2001_0005, 3'd0, 16'h0000, 26'h0,      32'h0,        1'b0, 1'b0, 0, 32'h0000_0004, 1,  2,  0, 0};
    vecs[1]  = '{0, 32'h8C22_0000, 3'd0, 16'h0000, 26'h0,      32'h0,        1'b1, 1'b0, 3, 32'h0000_0008, 2,  5,  4, 0};
    vecs[2]  = '{0, 32'h1000_FFFE, 3'd1, 16'hFFFE, 26'h0,      32'h0,        1'b0, 1'b0, 0, 32'h0000_0004, 3,  5,  0, 0};
    vecs[3]  = '{0, 32'h03E0_0008, 3'd3, 16'h0000, 26'h0,      32'h1000_0000, 1'b0, 1'b0, 0, 32'h1000_0000, 4,  5,  0, 0};
    vecs[4]  = '{0, 32'h0800_0040, 3'd2, 16'h0000, 26'h000_0040, 32'h0,      1'b0, 1'b0, 0, 32'h1000_0100, 5,  5,  0, 0};
    vecs[5]  = '{0, 32'h03E0_0008, 3'd3, 16'h0000, 26'h0,      32'h0000_0ABC, 1'b0, 1'b0, 0, 32'h0000_0ABC, 6,  5,  0, 0};
    vecs[6]  = '{1, 32'hAC22_0000, 3'd0, 16'h0000, 26'h0,      32'h0,        1'b0, 1'b1, 1, 32'h0000_0AC0, 7,  7,  0, 2};
    vecs[7]  = '{0, 32'h03E0_0008, 3'd3, 16'h0000, 26'h0,      32'hFFFF_FFFC, 1'b0, 1'b0, 0, 32'hFFFF_FFFC, 8,  7,  0, 0};
    vecs[8]  = '{0, 32'h2001_0001, 3'd0, 16'h0000, 26'h0,      32'h0,        1'b0, 1'b0, 0, 32'h0000_0000, 9,  7,  0, 0};
    vecs[9]  = '{3, 32'h2001_0002, 3'd7, 16'h1234, 26'h3FF_FFFF, 32'h5555_5555, 1'b0, 1'b0, 0, 32'h0000_0004, 10, 10, 0, 0};
    vecs[10] = '{0, 32'hAC22_0004, 3'd0, 16'h0000, 26'h0,      32'h0,        1'b1, 1'b1, 0, 32'h0000_0008, 11, 10, 0, 1};

    rst = 1'b1; ihit = 1'b0; dhit = 1'b0; dren = 1'b0; dwen = 1'b0; halt_in = 1'b0;
    iload = 32'h0; rs_data = 32'h0; pcsrc = 3'd0; imm = 16'h0; imm26 = 26'h0;
    tick(); tick();
    rst = 1'b0;

    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instruction, 32'h0);
    chk("rst_halted", {31'b0, halted}, 32'h0);
    chk("rst_pc_en", {31'b0, pc_en}, 32'h0);
    chk("rst_retired", retired_cnt, 32'h0);
    chk("rst_stall", stall_cnt, 32'h0);
    chk("rst_imemren", {31'b0, imemren}, 32'h1);
    $display("[TB] reset: pc=%h imemREN=%b", pc, imemren);

    for (int i = 0; i < 11; i++) run_instr(i, vecs[i]);

    // HALT decoded together with dWEN at pc=8
    halt_in = 1'b1; dwen = 1'b1; dren = 1'b0; pcsrc = 3'd0;
    ihit = 1'b1; iload = 32'hFC00_0000;
    tick();
    ihit = 1'b0;
    chk("halt_exec_wen", {31'b0, dmemwen}, 32'h0);
    chk("halt_exec_pc_en", {31'b0, pc_en}, 32'h0);
    tick();
    chk("halt_halted", {31'b0, halted}, 32'h1);
    ihit = 1'b1; dhit = 1'b1; dren = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    chk("halt_pc", pc, 32'h0000_0008);
    chk("halt_retired", retired_cnt, 32'd11);
    chk("halt_stall", stall_cnt, 32'd10);
    chk("halt_reqs", {29'b0, imemren, dmemren, dmemwen}, 32'h0);
    chk("halt_sticky", {31'b0, halted}, 32'h1);
    $display("[TB] halt: halted=%b pc=%h retired=%0d", halted, pc, retired_cnt);
    ihit = 1'b0; dhit = 1'b0; dren = 1'b0; dwen = 1'b0; halt_in = 1'b0;

    do_reset();
    chk("rst2_halted", {31'b0, halted}, 32'h0);
    chk("rst2_pc", pc, 32'h0);

    // Retire one instruction so pc moves off PC_INIT, then reset mid-MEM
    run_instr(11, '{0, 32'h2001_0005, 3'd0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0, 0,
                    32'h0000_0004, 1, 0, 0, 0});
    dren = 1'b1; ihit = 1'b1; iload = 32'h8C22_0000;
    tick();
    ihit = 1'b0;
    tick();
    tick();
    chk("midmem_ren", {31'b0, dmemren}, 32'h1);
    do_reset();
    chk("midmem_pc", pc, 32'h0);
    chk("midmem_ren_drop", {31'b0, dmemren}, 32'h0);
    chk("midmem_imemren", {31'b0, imemren}, 32'h1);
    chk("midmem_retired", retired_cnt, 32'h0);
    chk("midmem_stall", stall_cnt, 32'h0);
    chk("midmem_instr", instruction, 32'h0);
    $display("[TB] reset mid-MEM: pc=%h dmemREN=%b imemREN=%b", pc, dmemren, imemren);
    dren = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
